dmem_xbar: RTL and testbench

//  Parametrised 1-to-N data-memory interconnect between the ucrv32 dmem port and NUM_SLAVES targets (SRAM, UART, par-sim mailbox, ...).

---
 rtl/dmem_xbar.sv | 168 ++++++++++++++++
 tb/tb_dmem_xbar.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_xbar.sv
// rtl/dmem_xbar.sv - 1-to-N data-memory crossbar with in-order read response FIFO and decode-error reporting
module dmem_xbar #(
  parameter int                         NUM_SLAVES      = 3,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE      = {32'h1000_1000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK      = {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000},
  parameter int                         MAX_OUTSTANDING = 4,
  parameter logic [31:0]                ERR_DATA        = 32'hDEAD_BEEF,
  parameter int                         CNT_W           = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                m_req_addr,
  input  logic [31:0]                m_req_wdata,
  input  logic [3:0]                 m_req_wmask,
  input  logic                       m_req_write,
  input  logic                       m_req_valid,
  output logic                       m_req_ready,
  output logic                       m_resp_valid,
  input  logic                       m_resp_ready,
  output logic [31:0]                m_resp_rdata,
  output logic                       m_resp_err,
  output logic [31:0]                s_req_addr,
  output logic [31:0]                s_req_wdata,
  output logic [3:0]                 s_req_wmask,
  output logic                       s_req_write,
  output logic [NUM_SLAVES-1:0]      s_req_valid,
  input  logic [NUM_SLAVES-1:0]      s_req_ready,
  input  logic [NUM_SLAVES-1:0]      s_resp_valid,
  output logic [NUM_SLAVES-1:0]      s_resp_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_resp_rdata,
  output logic                       decode_err,
  output logic [CNT_W-1:0]           err_count,
  input  logic                       err_clear
);

  localparam int ID_W  = $clog2(NUM_SLAVES + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_W-1:0]  ERR_ID   = ID_W'(NUM_SLAVES);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(MAX_OUTSTANDING);

  logic [ID_W-1:0]  sel;
  logic             is_err;
  logic             issue_ok;
  logic             sel_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic [ID_W-1:0]  head_id;

  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]  tail_id_q, tail_id_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
  logic             decode_err_q, decode_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign s_req_addr  = m_req_addr;
  assign s_req_wdata = m_req_wdata;
  assign s_req_wmask = m_req_wmask;
  assign s_req_write = m_req_write;
  assign decode_err  = decode_err_q;
  assign err_count   = err_count_q;

  // Address decode: scan downward so the lowest matching index wins on overlap.
  always_comb begin
    sel = ERR_ID;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_req_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) sel = ID_W'(i);
    end
  end

  // Request routing: reads may only join the FIFO behind the same target, so responses stay ordered.
  always_comb begin
    is_err = (sel == ERR_ID);
    if (m_req_write) issue_ok = 1'b1;
    else             issue_ok = (cnt_q < FULL_CNT) && ((cnt_q == '0) || (sel == tail_id_q));
    sel_ready   = is_err;
    s_req_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == ID_W'(i)) begin
        s_req_valid[i] = m_req_valid & issue_ok;
        sel_ready      = s_req_ready[i];
      end
    end
    m_req_ready = issue_ok & sel_ready;
    accept      = m_req_valid & m_req_ready;
    push        = accept & ~m_req_write;
  end

  // Response steering from the FIFO head; the error target answers on its own.
  always_comb begin
    head_id      = fifo_q[rd_ptr_q];
    m_resp_valid = 1'b0;
    m_resp_rdata = '0;
    m_resp_err   = 1'b0;
    s_resp_ready = '0;
    if (cnt_q != '0) begin
      if (head_id == ERR_ID) begin
        m_resp_valid = 1'b1;
        m_resp_rdata = ERR_DATA;
        m_resp_err   = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (head_id == ID_W'(i)) begin
            m_resp_valid    = s_resp_valid[i];
            m_resp_rdata    = s_resp_rdata[i*32 +: 32];
            s_resp_ready[i] = m_resp_ready;
          end
        end
      end
    end
    pop = m_resp_valid & m_resp_ready;
  end

  // Next-state for the outstanding-read FIFO and the error bookkeeping.
  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tail_id_d    = tail_id_q;
    cnt_d        = cnt_q;
    decode_err_d = decode_err_q;
    err_count_d  = err_count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      tail_id_d        = sel;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (err_clear) begin
      decode_err_d = 1'b0;
      err_count_d  = '0;
    end else if (accept && is_err) begin
      decode_err_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end
  end

  // State registers; reset drops any pending responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tail_id_q    <= '0;
      fifo_q       <= '{default: '0};
      decode_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tail_id_q    <= tail_id_d;
      fifo_q       <= fifo_d;
      decode_err_q <= decode_err_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_dmem_xbar.sv
// tb/tb_dmem_xbar.sv - self-checking bench for dmem_xbar
module tb_dmem_xbar;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wmask;
  logic        m_req_write, m_req_valid, m_req_ready;
  logic        m_resp_valid, m_resp_ready, m_resp_err;
  logic [31:0] m_resp_rdata;
  logic [31:0] s_req_addr, s_req_wdata;
  logic [3:0]  s_req_wmask;
  logic        s_req_write;
  logic [2:0]  s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [95:0] s_resp_rdata;
  logic        decode_err, err_clear;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  logic [32:0] sb [$];
  logic [32:0] mon_e;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  srdy;
    logic [2:0]  exp_sv;
    logic        exp_rdy;
  } vec_t;
  vec_t vecs [8];

  dmem_xbar dut (
    .clk(clk), .reset(reset),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_req_write(m_req_write), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_req_write(s_req_write), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata),
    .decode_err(decode_err), .err_count(err_count), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request until accepted (bounded); reads queue their expected response.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] exp_d, input logic exp_e);
    int waits = 0;
    logic ok;
    m_req_addr  = a;
    m_req_write = w;
    m_req_wdata = a ^ 32'h5A5A_5A5A;
    m_req_valid = 1'b1;
    @(negedge clk);
    while (!m_req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    ok = m_req_ready;
    chk($sformatf("issue_accept_%0h", a), {31'b0, ok}, 32'd1);
    step();
    m_req_valid = 1'b0;
    if (ok && !w) sb.push_back({exp_e, exp_d});
  endtask

  // Response scoreboard: every handshake must match the oldest expected read.
  always @(negedge clk) begin
    if (!reset && m_resp_valid && m_resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got %0h want none", m_resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", m_resp_rdata, mon_e[31:0]);
        chk("resp_err", {31'b0, m_resp_err}, {31'b0, mon_e[32]});
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 1'b0, 3'b001, 3'b001, 1'b1};
    vecs[1] = '{32'h1000_0000, 1'b1, 3'b000, 3'b010, 1'b0};
    vecs[2] = '{32'h1000_0FFC, 1'b0, 3'b010, 3'b010, 1'b1};
    vecs[3] = '{32'h1000_1004, 1'b1, 3'b100, 3'b100, 1'b1};
    vecs[4] = '{32'h1000_2000, 1'b0, 3'b111, 3'b000, 1'b1};
    vecs[5] = '{32'h2000_0000, 1'b1, 3'b000, 3'b000, 1'b1};
    vecs[6] = '{32'h0FFF_FFFC, 1'b0, 3'b110, 3'b001, 1'b0};
    vecs[7] = '{32'hF000_0000, 1'b0, 3'b000, 3'b000, 1'b1};

    reset = 1'b1;
    m_req_addr = '0; m_req_wdata = '0; m_req_wmask = 4'hF; m_req_write = 1'b0; m_req_valid = 1'b0;
    m_resp_ready = 1'b0; s_req_ready = '0; s_resp_valid = '0; s_resp_rdata = '0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, m_resp_valid}, 32'd0);
    chk("rst_s_resp_ready", {29'b0, s_resp_ready}, 32'd0);
    chk("rst_s_req_valid", {29'b0, s_req_valid}, 32'd0);
    chk("rst_decode_err", {31'b0, decode_err}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    step();

    // decode table, checked combinationally with valid withdrawn before each edge
    for (int i = 0; i < 8; i++) begin
      m_req_addr = vecs[i].addr; m_req_write = vecs[i].write;
      s_req_ready = vecs[i].srdy; m_req_valid = 1'b1;
      #2;
      chk($sformatf("vec%0d_s_req_valid", i), {29'b0, s_req_valid}, {29'b0, vecs[i].exp_sv});
      chk($sformatf("vec%0d_m_req_ready", i), {31'b0, m_req_ready}, {31'b0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_bcast_addr", i), s_req_addr, vecs[i].addr);
      m_req_valid = 1'b0;
      step();
    end

    // single SRAM read
    s_req_ready = 3'b001;
    issue(32'h0000_0040, 1'b0, 32'h1234_5678, 1'b0);
    s_resp_valid = 3'b001; s_resp_rdata[31:0] = 32'h1234_5678; m_resp_ready = 1'b1;
    @(negedge clk);
    chk("rd_s_resp_ready", {29'b0, s_resp_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("rd_drained", {31'b0, m_resp_valid}, 32'd0);
    step();
    s_resp_valid = '0; m_resp_ready = 1'b0;

    // UART write stalled 3 cycles
    m_req_addr = 32'h1000_0000; m_req_write = 1'b1; m_req_valid = 1'b1; s_req_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wr_stall%0d", k), {31'b0, m_req_ready}, 32'd0);
      chk($sformatf("wr_stall_sv%0d", k), {29'b0, s_req_valid}, 32'd2);
      step();
    end
    s_req_ready = 3'b010;
    @(negedge clk);
    chk("wr_accept", {31'b0, m_req_ready}, 32'd1);
    step();
    m_req_valid = 1'b0; m_resp_ready = 1'b1;
    repeat (2) step();
    chk("wr_no_resp", {31'b0, m_resp_valid}, 32'd0);
    m_resp_ready = 1'b0;

    // FIFO full with four SRAM reads
    s_req_ready = 3'b001;
    for (int k = 0; k < 4; k++) issue(32'h100 + 32'(4 * k), 1'b0, 32'hA000_0000 + 32'(k), 1'b0);
    m_req_addr = 32'h200; m_req_write = 1'b0; m_req_valid = 1'b1;
    @(negedge clk);
    chk("full_block0", {31'b0, m_req_ready}, 32'd0);
    @(negedge clk);
    chk("full_block1", {31'b0, m_req_ready}, 32'd0);
    step();
    s_resp_valid = 3'b001; s_resp_rdata[31:0] = 32'hA000_0000; m_resp_ready = 1'b1;
    @(negedge clk);
    chk("full_block_on_pop", {31'b0, m_req_ready}, 32'd0);
    step();
    s_resp_valid = '0;
    @(negedge clk);
    chk("full_issue_after_pop", {31'b0, m_req_ready}, 32'd1);
    step();
    m_req_valid = 1'b0;
    sb.push_back({1'b0, 32'hA000_0004});
    for (int k = 1; k <= 4; k++) begin
      s_resp_valid = 3'b001; s_resp_rdata[31:0] = 32'hA000_0000 + 32'(k);
      step();
    end
    s_resp_valid = '0; m_resp_ready = 1'b0;
    chk("full_drained", {31'b0, m_resp_valid}, 32'd0);

    // cross-target ordering: UART read waits for the SRAM read
    s_req_ready = 3'b011;
    issue(32'h0000_0080, 1'b0, 32'hB000_0000, 1'b0);
    m_req_addr = 32'h1000_0010; m_req_write = 1'b0; m_req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("xord_sv%0d", k), {29'b0, s_req_valid}, 32'd0);
      chk($sformatf("xord_rdy%0d", k), {31'b0, m_req_ready}, 32'd0);
      step();
    end
    s_resp_valid = 3'b001; s_resp_rdata[31:0] = 32'hB000_0000; m_resp_ready = 1'b1;
    @(negedge clk);
    chk("xord_sv_on_pop", {29'b0, s_req_valid}, 32'd0);
    step();
    s_resp_valid = '0;
    @(negedge clk);
    chk("xord_sv_go", {29'b0, s_req_valid}, 32'd2);
    chk("xord_rdy_go", {31'b0, m_req_ready}, 32'd1);
    step();
    m_req_valid = 1'b0;
    sb.push_back({1'b0, 32'hC000_0000});
    s_resp_valid = 3'b011; s_resp_rdata[63:32] = 32'hC000_0000; s_resp_rdata[31:0] = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("xord_head_only_ready", {29'b0, s_resp_ready}, 32'd2);
    step();
    s_resp_valid = '0; m_resp_ready = 1'b0;

    // unmapped read
    issue(32'h2000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("err_resp_valid", {31'b0, m_resp_valid}, 32'd1);
    chk("err_rdata", m_resp_rdata, 32'hDEAD_BEEF);
    chk("err_flag", {31'b0, m_resp_err}, 32'd1);
    chk("err_sticky", {31'b0, decode_err}, 32'd1);
    chk("err_count1", {24'b0, err_count}, 32'd1);
    step();
    m_resp_ready = 1'b1;
    step();
    m_resp_ready = 1'b0;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_decode_err", {31'b0, decode_err}, 32'd0);
    chk("clr_err_count", {24'b0, err_count}, 32'd0);

    // saturation, then clear winning over a same-cycle error
    m_req_addr = 32'h3000_0000; m_req_write = 1'b1; m_req_valid = 1'b1;
    repeat (260) step();
    chk("sat_count", {24'b0, err_count}, 32'hFF);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0; m_req_valid = 1'b0;
    chk("clr_prio_count", {24'b0, err_count}, 32'd0);
    chk("clr_prio_flag", {31'b0, decode_err}, 32'd0);
    issue(32'h3000_0004, 1'b1, 32'd0, 1'b0);
    chk("post_clr_count", {24'b0, err_count}, 32'd1);

    // reset with two reads outstanding
    s_req_ready = 3'b001;
    issue(32'h0000_0040, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0044, 1'b0, 32'h0, 1'b0);
    s_resp_valid = 3'b001; s_resp_rdata[31:0] = 32'h7777_7777;
    #1 reset = 1'b1;
    #1;
    chk("arst_resp_valid", {31'b0, m_resp_valid}, 32'd0);
    chk("arst_s_resp_ready", {29'b0, s_resp_ready}, 32'd0);
    sb.delete();
    m_req_addr = 32'h0000_0040; m_req_write = 1'b0; m_req_valid = 1'b1;
    #1;
    chk("arst_s_req_valid", {29'b0, s_req_valid}, 32'd1);
    m_req_valid = 1'b0; m_resp_ready = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_valid", {31'b0, m_resp_valid}, 32'd0);
    chk("post_rst_s_resp_ready", {29'b0, s_resp_ready}, 32'd0);
    step();
    s_resp_valid = '0; m_resp_ready = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
